// File: rtl/ucore_cfg_loader.sv
// Purpose: packs BUS_WIDTH config beats into CFG_WIDTH words and strobes them into the ucore chain head.
// Latency: final-beat handshake at cycle N -> cfg_en/cfg_in at N+1; cfg_done one cycle after the last word.
// Backpressure: in_ready is high only in LOAD; the chain head never stalls, so words go out back-to-back.
module ucore_cfg_loader #(
    parameter int BUS_WIDTH = 32,
    parameter int CFG_WIDTH = 64,
    parameter int CHAIN_LEN = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             abort,
    input  logic                             in_valid,
    input  logic [BUS_WIDTH-1:0]             in_data,
    output logic                             in_ready,
    output logic                             cfg_en,
    output logic [CFG_WIDTH-1:0]             cfg_in,
    output logic                             cfg_done,
    output logic                             busy,
    output logic [$clog2(CHAIN_LEN+1)-1:0]   word_count
);

    localparam int BEATS = CFG_WIDTH / BUS_WIDTH;
    localparam int BIW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WCW   = $clog2(CHAIN_LEN + 1);
    localparam logic [BIW-1:0] LAST_BEAT = BIW'(BEATS - 1);
    localparam logic [WCW-1:0] LAST_WORD = WCW'(CHAIN_LEN - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [BIW-1:0]       beat_idx;
    logic [CFG_WIDTH-1:0] asm_q;
    logic [CFG_WIDTH-1:0] asm_nxt;
    logic                 beat_hs;
    logic                 word_last_beat;
    logic                 load_start;

    // in_ready depends on state only, so the upstream never sees a combinational path from valid.
    assign in_ready = (state == LOAD);

    // An abort in the same cycle as a beat kills the handshake, so a final beat cannot complete a word.
    assign beat_hs        = in_valid & in_ready & ~abort;
    assign word_last_beat = beat_hs & (beat_idx == LAST_BEAT);
    assign load_start     = (state == IDLE) & start & ~abort;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode; abort overrides every transition.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    if (word_last_beat && (word_count == LAST_WORD)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = IDLE;
        end
    end

    // Assembly register with the current beat dropped into its slice.
    always_comb begin
        asm_nxt = asm_q;
        asm_nxt[int'(beat_idx) * BUS_WIDTH +: BUS_WIDTH] = in_data;
    end

    // Registered outputs, beat position and partial-word storage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cfg_en     <= 1'b0;
            cfg_done   <= 1'b0;
            busy       <= 1'b0;
            cfg_in     <= '0;
            word_count <= '0;
            beat_idx   <= '0;
            asm_q      <= '0;
        end else begin
            cfg_en   <= word_last_beat;
            cfg_done <= (state == DONE) & ~abort;
            busy     <= (state_nxt != IDLE);
            if (load_start) begin
                word_count <= '0;
                beat_idx   <= '0;
            end else if (beat_hs) begin
                asm_q <= asm_nxt;
                if (beat_idx == LAST_BEAT) begin
                    beat_idx   <= '0;
                    word_count <= word_count + 1'b1;
                    cfg_in     <= asm_nxt;
                end else begin
                    beat_idx <= beat_idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ucore_cfg_loader.sv
// Bench for ucore_cfg_loader: two instances (CHAIN_LEN=2 and CHAIN_LEN=4), 32->64 bit packing.
// Stimulus pushes expected cfg_en/cfg_done events with their sample time; a negedge monitor pops and compares.
// Direct checks cover reset values, busy/in_ready/word_count and abort/reset corner cases.
module tb_ucore_cfg_loader;

    logic        clk;
    logic        reset;

    logic        a_start, a_abort, a_valid, a_ready, a_en, a_done, a_busy;
    logic [31:0] a_data;
    logic [63:0] a_cfg;
    logic [1:0]  a_wc;

    logic        b_start, b_abort, b_valid, b_ready, b_en, b_done, b_busy;
    logic [31:0] b_data;
    logic [63:0] b_cfg;
    logic [2:0]  b_wc;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit          is_done;
        logic [63:0] data;
        time         t;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    ucore_cfg_loader #(.BUS_WIDTH(32), .CFG_WIDTH(64), .CHAIN_LEN(2)) u_dut_a (
        .clk(clk), .reset(reset), .start(a_start), .abort(a_abort),
        .in_valid(a_valid), .in_data(a_data), .in_ready(a_ready),
        .cfg_en(a_en), .cfg_in(a_cfg), .cfg_done(a_done), .busy(a_busy), .word_count(a_wc)
    );

    ucore_cfg_loader #(.BUS_WIDTH(32), .CFG_WIDTH(64), .CHAIN_LEN(4)) u_dut_b (
        .clk(clk), .reset(reset), .start(b_start), .abort(b_abort),
        .in_valid(b_valid), .in_data(b_data), .in_ready(b_ready),
        .cfg_en(b_en), .cfg_in(b_cfg), .cfg_done(b_done), .busy(b_busy), .word_count(b_wc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input bit b, input bit is_done, input logic [63:0] data, input time t);
        exp_t e;
        e.is_done = is_done;
        e.data    = data;
        e.t       = t;
        if (b) qb.push_back(e);
        else   qa.push_back(e);
    endtask

    task automatic sb_check(input bit b, input bit is_done, input logic [63:0] data);
        exp_t e;
        int   n;
        n = b ? qb.size() : qa.size();
        total++;
        if (n == 0) begin
            bad++;
            $display("FAIL sb_unexpected dut=%0d done=%0d act=%h exp=no_event at t=%0t", b, is_done, data, $time);
        end else begin
            if (b) e = qb.pop_front();
            else   e = qa.pop_front();
            chk("sb_kind", 64'(is_done), 64'(e.is_done));
            if (!is_done) chk("sb_cfg_in", data, e.data);
            chk("sb_time", 64'($time), 64'(e.t));
        end
    endtask

    // Monitor: every strobe the DUTs present is matched against the scoreboard.
    always @(negedge clk) begin
        if (!reset) begin
            if (a_en)   sb_check(1'b0, 1'b0, a_cfg);
            if (a_done) sb_check(1'b0, 1'b1, 64'd0);
            if (b_en)   sb_check(1'b1, 1'b0, b_cfg);
            if (b_done) sb_check(1'b1, 1'b1, 64'd0);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_load(input bit b);
        if (b) b_start = 1'b1;
        else   a_start = 1'b1;
        @(posedge clk);
        #1;
        b_start = 1'b0;
        a_start = 1'b0;
        chk("busy_after_start", 64'(b ? b_busy : a_busy), 64'd1);
        chk("ready_after_start", 64'(b ? b_ready : a_ready), 64'd1);
    endtask

    task automatic beat(input bit b, input logic [31:0] d, input bit word_end,
                        input logic [63:0] w, input bit load_end);
        time t;
        if (b) begin
            b_valid = 1'b1;
            b_data  = d;
        end else begin
            a_valid = 1'b1;
            a_data  = d;
        end
        chk("ready_in_load", 64'(b ? b_ready : a_ready), 64'd1);
        @(posedge clk);
        t = $time;
        if (word_end) push(b, 1'b0, w, t + 5);
        if (load_end) push(b, 1'b1, 64'd0, t + 15);
        #1;
        if (b) b_valid = 1'b0;
        else   a_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        a_start = 1'b0; a_abort = 1'b0; a_valid = 1'b0; a_data = 32'h0;
        b_start = 1'b0; b_abort = 1'b0; b_valid = 1'b0; b_data = 32'h0;
        #12;
        chk("rst_cfg_en", 64'(a_en), 64'd0);
        chk("rst_cfg_done", 64'(a_done), 64'd0);
        chk("rst_busy", 64'(a_busy), 64'd0);
        chk("rst_in_ready", 64'(a_ready), 64'd0);
        chk("rst_word_count", 64'(a_wc), 64'd0);
        chk("rst_cfg_in", a_cfg, 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);

        // 1: four beats, one per cycle -> two words, then done
        start_load(1'b0);
        beat(1'b0, 32'h11, 1'b0, 64'h0, 1'b0);
        beat(1'b0, 32'h22, 1'b1, 64'h00000022_00000011, 1'b0);
        beat(1'b0, 32'h33, 1'b0, 64'h0, 1'b0);
        beat(1'b0, 32'h44, 1'b1, 64'h00000044_00000033, 1'b1);
        // 6a: valid held in DONE and IDLE must not be consumed
        a_valid = 1'b1;
        a_data  = 32'h99;
        chk("t1_busy_in_done", 64'(a_busy), 64'd1);
        chk("t1_ready_in_done", 64'(a_ready), 64'd0);
        idle(1);
        chk("t1_busy_fall", 64'(a_busy), 64'd0);
        chk("t1_ready_in_idle", 64'(a_ready), 64'd0);
        idle(2);
        a_valid = 1'b0;
        chk("t1_word_count", 64'(a_wc), 64'd2);
        chk("t1_cfg_in_hold", a_cfg, 64'h00000044_00000033);
        chk("t1_queue_empty", 64'(qa.size()), 64'd0);

        // 2: stall mid-word, same words expected
        start_load(1'b0);
        beat(1'b0, 32'h11, 1'b0, 64'h0, 1'b0);
        idle(3);
        beat(1'b0, 32'h22, 1'b1, 64'h00000022_00000011, 1'b0);
        idle(3);
        beat(1'b0, 32'h33, 1'b0, 64'h0, 1'b0);
        beat(1'b0, 32'h44, 1'b1, 64'h00000044_00000033, 1'b1);
        idle(3);
        chk("t2_word_count", 64'(a_wc), 64'd2);
        chk("t2_queue_empty", 64'(qa.size()), 64'd0);

        // 4: start pulsed during LOAD is ignored
        start_load(1'b0);
        beat(1'b0, 32'h11, 1'b0, 64'h0, 1'b0);
        a_start = 1'b1;
        beat(1'b0, 32'h22, 1'b1, 64'h00000022_00000011, 1'b0);
        chk("t4_word_count_mid", 64'(a_wc), 64'd1);
        beat(1'b0, 32'h33, 1'b0, 64'h0, 1'b0);
        a_start = 1'b0;
        beat(1'b0, 32'h44, 1'b1, 64'h00000044_00000033, 1'b1);
        idle(3);
        chk("t4_word_count", 64'(a_wc), 64'd2);
        chk("t4_queue_empty", 64'(qa.size()), 64'd0);

        // 5: async reset mid-word, then a clean reload
        start_load(1'b0);
        beat(1'b0, 32'h55, 1'b0, 64'h0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_cfg_en", 64'(a_en), 64'd0);
        chk("t5_cfg_done", 64'(a_done), 64'd0);
        chk("t5_busy", 64'(a_busy), 64'd0);
        chk("t5_in_ready", 64'(a_ready), 64'd0);
        chk("t5_word_count", 64'(a_wc), 64'd0);
        chk("t5_cfg_in", a_cfg, 64'd0);
        #3;
        reset = 1'b0;
        idle(1);
        start_load(1'b0);
        beat(1'b0, 32'h66, 1'b0, 64'h0, 1'b0);
        beat(1'b0, 32'h77, 1'b1, 64'h00000077_00000066, 1'b0);
        beat(1'b0, 32'h88, 1'b0, 64'h0, 1'b0);
        beat(1'b0, 32'h99, 1'b1, 64'h00000099_00000088, 1'b1);
        idle(3);
        chk("t5_word_count_reload", 64'(a_wc), 64'd2);
        chk("t5_queue_empty", 64'(qa.size()), 64'd0);

        // 6b: abort on the final beat of a word drops it
        start_load(1'b0);
        beat(1'b0, 32'hA1, 1'b0, 64'h0, 1'b0);
        a_valid = 1'b1;
        a_data  = 32'hA2;
        a_abort = 1'b1;
        @(posedge clk);
        #1;
        a_abort = 1'b0;
        a_valid = 1'b0;
        chk("t6_abort_busy", 64'(a_busy), 64'd0);
        chk("t6_abort_ready", 64'(a_ready), 64'd0);
        chk("t6_abort_word_count", 64'(a_wc), 64'd0);
        idle(3);
        chk("t6_abort_queue_empty", 64'(qa.size()), 64'd0);
        start_load(1'b0);
        beat(1'b0, 32'hB1, 1'b0, 64'h0, 1'b0);
        beat(1'b0, 32'hB2, 1'b1, 64'h000000B2_000000B1, 1'b0);
        beat(1'b0, 32'hB3, 1'b0, 64'h0, 1'b0);
        beat(1'b0, 32'hB4, 1'b1, 64'h000000B4_000000B3, 1'b1);
        idle(3);
        chk("t6_reload_word_count", 64'(a_wc), 64'd2);

        // 3: CHAIN_LEN=4, abort after first word plus one extra beat
        start_load(1'b1);
        beat(1'b1, 32'h11, 1'b0, 64'h0, 1'b0);
        beat(1'b1, 32'h22, 1'b1, 64'h00000022_00000011, 1'b0);
        beat(1'b1, 32'h33, 1'b0, 64'h0, 1'b0);
        b_abort = 1'b1;
        @(posedge clk);
        #1;
        b_abort = 1'b0;
        chk("t3_busy", 64'(b_busy), 64'd0);
        chk("t3_word_count", 64'(b_wc), 64'd1);
        b_valid = 1'b1;
        b_data  = 32'h44;
        for (int i = 0; i < 3; i++) begin
            chk("t3_ready_idle", 64'(b_ready), 64'd0);
            idle(1);
        end
        b_valid = 1'b0;
        idle(3);
        chk("t3_word_count_hold", 64'(b_wc), 64'd1);
        chk("t3_cfg_in_hold", b_cfg, 64'h00000022_00000011);
        chk("t3_queue_empty", 64'(qb.size()), 64'd0);
        chk("final_queue_a_empty", 64'(qa.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
